// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and sequencer that shares a 16x24 single-port data memory between two requesters.
// Optional macro DATA_MEM_ARB_WPROT_EN refuses requester-1 writes below PROT_LIMIT.
module data_mem_arbiter #(
    parameter int DEPTH      = 16,
    parameter int AW         = 5,
    parameter int DW         = 24,
    parameter int PROT_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] PROT_L  = (AW+1)'(PROT_LIMIT);
`ifdef DATA_MEM_ARB_WPROT_EN
    localparam logic WPROT = 1'b1;
`else
    localparam logic WPROT = 1'b0;
`endif

    state_t        state_q, state_d;
    logic          ptr_q;      // 1: requester 1 is favoured on a tie
    logic          owner_q;
    logic          we_q;
    logic          err_q;      // out of range or refused: memory is never written
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    logic          accept, gnt0, gnt1, hs, sel1;
    logic          sel_we, sel_err, out_range, prot_hit;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Arbitration and selection of the winning request.
    always_comb begin
        accept    = (state_q == IDLE) || (state_q == RESP);
        gnt0      = r0_valid & (~r1_valid | ~ptr_q);
        gnt1      = r1_valid & (~r0_valid | ptr_q);
        r0_ready  = accept & gnt0;
        r1_ready  = accept & gnt1;
        hs        = r0_ready | r1_ready;
        sel1      = r1_ready;
        sel_we    = sel1 ? r1_we    : r0_we;
        sel_addr  = sel1 ? r1_addr  : r0_addr;
        sel_wdata = sel1 ? r1_wdata : r0_wdata;
        out_range = {1'b0, sel_addr} >= DEPTH_L;
        prot_hit  = WPROT & sel1 & sel_we & ({1'b0, sel_addr} < PROT_L);
        sel_err   = out_range | prot_hit;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = hs ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                ptr_q   <= ~sel1;
                owner_q <= sel1;
                we_q    <= sel_we;
                err_q   <= sel_err;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
        end
    end

    // Reset gates the write strobe directly so a write caught in ISSUE is dropped.
    assign mem_we     = (state_q == ISSUE) & we_q & ~err_q & ~rst;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign rsp0_valid = (state_q == RESP) & ~owner_q;
    assign rsp1_valid = (state_q == RESP) & owner_q;
    assign rsp_err    = (state_q == RESP) & err_q;
    assign rsp_rdata  = ((state_q == RESP) & ~err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 16x24 read-before-write memory.
// Honours DATA_MEM_ARB_WPROT_EN when the design is built with it.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_valid = 1'b0, r0_we = 1'b0;
    logic [4:0]  r0_addr = '0;
    logic [23:0] r0_wdata = '0;
    logic        r1_valid = 1'b0, r1_we = 1'b0;
    logic [4:0]  r1_addr = '0;
    logic [23:0] r1_wdata = '0;
    logic        r0_ready, r1_ready, rsp0_valid, rsp1_valid, rsp_err, mem_we;
    logic [23:0] rsp_rdata, mem_wdata;
    logic [23:0] mem_rdata = '0;
    logic [4:0]  mem_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [23:0] mem [16];

    data_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory decodes only the low 4 address bits.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[3:0]];
        if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
    end

    // One full transaction; called and returning at posedge+1.
    task automatic do_req(input bit req, input logic we, input logic [4:0] addr, input logic [23:0] wd,
                          output int waits, output logic [23:0] rd, output logic er,
                          output logic v0, output logic v1, output logic saw_we);
        waits = 0;
        if (req) begin
            r1_valid = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wd;
        end else begin
            r0_valid = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wd;
        end
        @(negedge clk);
        while (!(req ? r1_ready : r0_ready) && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        @(negedge clk);
        saw_we = mem_we;
        @(negedge clk);
        saw_we = saw_we | mem_we;
        rd = rsp_rdata; er = rsp_err; v0 = rsp0_valid; v1 = rsp1_valid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp0_valid got %b want 0", rsp0_valid); end
        n_cmp++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp1_valid got %b want 0", rsp1_valid); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 5'd0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 24'd0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        n_cmp++; if (rsp_rdata !== 24'd0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_read();
        int w; logic [23:0] rd; logic er, v0, v1, sw;
        do_req(1'b0, 1'b0, 5'd3, 24'd0, w, rd, er, v0, v1, sw);
        n_cmp++; if (w !== 0) begin n_fail++; $display("FAIL read_wait got %0d want 0", w); end
        n_cmp++; if (v0 !== 1'b1 || v1 !== 1'b0) begin n_fail++; $display("FAIL read_owner got %b%b want 10", v0, v1); end
        n_cmp++; if (rd !== 24'h654321) begin n_fail++; $display("FAIL read_data got %h want 654321", rd); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL read_err got %b want 0", er); end
        n_cmp++; if (sw !== 1'b0) begin n_fail++; $display("FAIL read_mem_we got %b want 0", sw); end
    endtask

    task automatic test_write_read();
        int w; logic [23:0] rd; logic er, v0, v1, sw;
        do_req(1'b1, 1'b1, 5'd5, 24'hABCDEF, w, rd, er, v0, v1, sw);
        n_cmp++; if (v0 !== 1'b0 || v1 !== 1'b1) begin n_fail++; $display("FAIL wr_owner got %b%b want 01", v0, v1); end
        n_cmp++; if (rd !== 24'h654321) begin n_fail++; $display("FAIL wr_old_data got %h want 654321", rd); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_err got %b want 0", er); end
        n_cmp++; if (sw !== 1'b1) begin n_fail++; $display("FAIL wr_mem_we got %b want 1", sw); end
        do_req(1'b1, 1'b0, 5'd5, 24'd0, w, rd, er, v0, v1, sw);
        n_cmp++; if (rd !== 24'hABCDEF) begin n_fail++; $display("FAIL wr_readback got %h want abcdef", rd); end
        n_cmp++; if (v1 !== 1'b1) begin n_fail++; $display("FAIL wr_readback_owner got %b want 1", v1); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] e_rdy0 = 11'b00100010001;
        logic [10:0] e_rdy1 = 11'b00001000100;
        logic [10:0] e_v0   = 11'b10001000100;
        logic [10:0] e_v1   = 11'b00100010000;
        logic [23:0] e_d;
        r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 5'd4;
        r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 5'd8;
        for (int k = 0; k < 11; k++) begin
            if (k == 7) r1_valid = 1'b0;
            if (k == 9) r0_valid = 1'b0;
            e_d = e_v0[k] ? 24'h123456 : (e_v1[k] ? 24'h999999 : 24'h0);
            @(negedge clk);
            n_cmp++; if (r0_ready !== e_rdy0[k] || r1_ready !== e_rdy1[k]) begin
                n_fail++; $display("FAIL b2b_ready cyc %0d got %b%b want %b%b", k, r0_ready, r1_ready, e_rdy0[k], e_rdy1[k]); end
            n_cmp++; if (rsp0_valid !== e_v0[k] || rsp1_valid !== e_v1[k]) begin
                n_fail++; $display("FAIL b2b_rsp cyc %0d got %b%b want %b%b", k, rsp0_valid, rsp1_valid, e_v0[k], e_v1[k]); end
            n_cmp++; if (rsp_rdata !== e_d) begin
                n_fail++; $display("FAIL b2b_data cyc %0d got %h want %h", k, rsp_rdata, e_d); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_out_of_range();
        int w; logic [23:0] rd; logic er, v0, v1, sw;
        do_req(1'b0, 1'b1, 5'd20, 24'h777777, w, rd, er, v0, v1, sw);
        n_cmp++; if (sw !== 1'b0) begin n_fail++; $display("FAIL oor_mem_we got %b want 0", sw); end
        n_cmp++; if (v0 !== 1'b1) begin n_fail++; $display("FAIL oor_rsp0 got %b want 1", v0); end
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_err got %b want 1", er); end
        n_cmp++; if (rd !== 24'h0) begin n_fail++; $display("FAIL oor_data got %h want 0", rd); end
        do_req(1'b0, 1'b0, 5'd4, 24'd0, w, rd, er, v0, v1, sw);
        n_cmp++; if (rd !== 24'h123456 || er !== 1'b0) begin
            n_fail++; $display("FAIL oor_alias got %h/%b want 123456/0", rd, er); end
    endtask

    task automatic test_reset_mid();
        int w; logic [23:0] rd; logic er, v0, v1, sw;
        r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 5'd6; r0_wdata = 24'h111111;
        @(negedge clk);
        n_cmp++; if (r0_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", r0_ready); end
        @(posedge clk); #1;
        r0_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_we got %b want 0", mem_we); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rsp0 cyc %0d got %b want 0", k, rsp0_valid); end
            @(posedge clk); #1;
        end
        do_req(1'b0, 1'b0, 5'd6, 24'd0, w, rd, er, v0, v1, sw);
        n_cmp++; if (rd !== 24'h123456) begin n_fail++; $display("FAIL rstmid_readback got %h want 123456", rd); end
    endtask

    task automatic test_wprot();
        int w; logic [23:0] rd; logic er, v0, v1, sw;
`ifdef DATA_MEM_ARB_WPROT_EN
        do_req(1'b1, 1'b1, 5'd1, 24'h0A0B0C, w, rd, er, v0, v1, sw);
        n_cmp++; if (er !== 1'b1 || rd !== 24'h0) begin n_fail++; $display("FAIL wprot_r1 got %h/%b want 0/1", rd, er); end
        n_cmp++; if (sw !== 1'b0) begin n_fail++; $display("FAIL wprot_r1_mem_we got %b want 0", sw); end
        do_req(1'b1, 1'b0, 5'd1, 24'd0, w, rd, er, v0, v1, sw);
        n_cmp++; if (rd !== 24'h008000 || er !== 1'b0) begin n_fail++; $display("FAIL wprot_read got %h/%b want 008000/0", rd, er); end
        do_req(1'b0, 1'b1, 5'd1, 24'h0A0B0C, w, rd, er, v0, v1, sw);
        n_cmp++; if (er !== 1'b0 || rd !== 24'h008000) begin n_fail++; $display("FAIL wprot_r0 got %h/%b want 008000/0", rd, er); end
`else
        do_req(1'b1, 1'b1, 5'd1, 24'h0A0B0C, w, rd, er, v0, v1, sw);
        n_cmp++; if (er !== 1'b0 || rd !== 24'h008000) begin n_fail++; $display("FAIL noprot_r1 got %h/%b want 008000/0", rd, er); end
        n_cmp++; if (sw !== 1'b1) begin n_fail++; $display("FAIL noprot_mem_we got %b want 1", sw); end
`endif
        do_req(1'b0, 1'b0, 5'd1, 24'd0, w, rd, er, v0, v1, sw);
        n_cmp++; if (rd !== 24'h0A0B0C) begin n_fail++; $display("FAIL prot_readback got %h want 0a0b0c", rd); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 24'h123456;
        mem[1] = 24'h008000;
        mem[3] = 24'h654321;
        mem[5] = 24'h654321;
        mem[8] = 24'h999999;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_read();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        test_wprot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Two-requester arbiter and sequencer for the 16x24 single-port data memory (1-cycle registered read, read-before-write).
- Shares the memory between requester 0 (core load/store unit) and requester 1 (loader/DMA) using round-robin arbitration and valid/ready handshakes.
- Drives the memory's we/addr/data_in from registered state and returns read data or write-acks to the owning requester.
- Traps out-of-range addresses so they never reach the memory.

Parameters:
DEPTH, 16, number of implemented memory words; addresses >= DEPTH are out of range
AW, 5, address width (matches memory addr port)
DW, 24, data width (matches memory data ports)
PROT_LIMIT, 3, write-protect boundary used only by the optional feature

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
r0_valid  in  1  requester 0 request valid
r0_ready  out  1  requester 0 request accepted this cycle
r0_we  in  1  requester 0 write (1) / read (0)
r0_addr  in  AW  requester 0 word address
r0_wdata  in  DW  requester 0 write data
r1_valid, r1_ready, r1_we, r1_addr, r1_wdata  same as r0_*, requester 1
rsp0_valid  out  1  one-cycle response pulse to requester 0
rsp1_valid  out  1  one-cycle response pulse to requester 1
rsp_rdata  out  DW  response data, shared, valid with rspN_valid
rsp_err  out  1  response error flag, shared, valid with rspN_valid
mem_we  out  1  to memory we
mem_addr  out  AW  to memory addr
mem_wdata  out  DW  to memory data_in
mem_rdata  in  DW  from memory data_out

Behaviour:
- Reset: one clock, synchronous, active-high. While rst is high at a posedge:
  - state goes to IDLE; RR pointer favours r0.
  - all registered outputs clear: rsp0_valid=0, rsp1_valid=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rsp_err=0; rsp_rdata is 0 whenever no rspN_valid is high.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: rN_ready combinational. Only the arbitration winner sees ready=1, and only if its rN_valid=1. On handshake, latch we/addr/wdata/owner/range bit, go to ISSUE. No handshake: stay in IDLE.
  - ISSUE: mem_addr/mem_wdata come from latched regs. mem_we = latched_we & in_range & ~rst (combinational gate on rst). Both readies low. Always go to RESP.
  - RESP: the owner's rspN_valid=1 for exactly this cycle.
    - In range: rsp_rdata=mem_rdata, rsp_err=0.
    - Out of range: rsp_rdata=0, rsp_err=1.
    - Writes also respond; rsp_rdata = contents before the write (memory is read-before-write).
    - Ready is raised as in IDLE. A handshake here goes to ISSUE (back-to-back); otherwise go to IDLE.
- Latency: handshake in cycle N, memory access edge ends N+1, response in cycle N+2. Peak throughput is 1 request per 2 cycles.
- Arbitration:
  - Only r0 valid: r0 wins. Only r1 valid: r1 wins.
  - Both valid: the requester not granted last wins.
  - Pointer updates only on handshake.
- Requester rules: rN_valid and payload must stay stable until ready is seen. The arbiter never drops a valid request; an unchosen requester keeps waiting.
- Range: addr >= DEPTH (16..31 at defaults) is out of range. mem_we stays 0 for the whole transaction and the memory is untouched.
- Reset mid-operation: a write in ISSUE is dropped. A pending response is not produced. Requests pending at reset are ignored and must be re-presented.
- No response backpressure: requesters must accept the rspN_valid pulse.

Optional Feature:
Macro DATA_MEM_ARB_WPROT_EN.
- Defined: r1 writes with addr < PROT_LIMIT are refused. They are accepted normally, but mem_we stays 0 and the response is rsp_err=1, rsp_rdata=0. r0 writes and all reads are unaffected.
- Undefined: no protection logic is present, PROT_LIMIT is unused, and r1 writes behave like r0 writes.

Test Plan:
- After reset, r0 reads addr 3 -> r0_ready=1 in cycle N; rsp0_valid=1 in N+2 with rsp_rdata=24'h654321, rsp_err=0.
- r1 writes 24'hABCDEF to addr 5, then r1 reads addr 5 -> write response rsp_rdata=24'h654321 (old data); read response 24'hABCDEF.
- r0 and r1 both hold valid continuously, reads of addr 4 and 8 -> grants alternate r0,r1,r0,r1; r1's responses return 24'h999999, r0's return 24'h123456; accepts every 2 cycles.
- r0 writes addr 20 -> mem_we never 1; rsp0_valid with rsp_err=1, rsp_rdata=0; a later read of addr 4 (alias of 20 in 4-bit decode) still returns 24'h123456.
- r0 write to addr 6 accepted, rst pulsed during ISSUE -> mem_we=0, no rsp0_valid, a read of addr 6 after reset returns 24'h123456.
- With DATA_MEM_ARB_WPROT_EN: r1 writes addr 1 -> rsp_err=1, a read of addr 1 returns 24'h008000; the same write from r0 succeeds.
